// File: rtl/kernel_row_buffer.sv
// Ping-pong kernel row buffer: captures kernel ROM rows per conv lane into a fill
// bank and presents each completed kernel to the four lanes with a valid/consume handshake.
module kernel_row_buffer #(
    parameter int SLOT_W   = 16,
    parameter int MAX_ROWS = 16,
    parameter int CNT_W    = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic [CNT_W-1:0]           row_size,
    input  logic                       rdata_valid,
    input  logic [4*SLOT_W-1:0]        kernel_rdata,
    input  logic [1:0]                 kernel_select_0,
    input  logic [1:0]                 kernel_select_1,
    input  logic [1:0]                 kernel_select_2,
    input  logic [1:0]                 kernel_select_3,
    input  logic                       kernel_consume,
    output logic                       fill_ready,
    output logic                       kernel_valid,
    output logic [MAX_ROWS*SLOT_W-1:0] kernel_data_0,
    output logic [MAX_ROWS*SLOT_W-1:0] kernel_data_1,
    output logic [MAX_ROWS*SLOT_W-1:0] kernel_data_2,
    output logic [MAX_ROWS*SLOT_W-1:0] kernel_data_3,
    output logic [CNT_W-1:0]           kernel_rows,
    output logic                       overflow
);

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [CNT_W-1:0] size_q_reg;
    logic [CNT_W-1:0] hold_rows_reg;
    logic [CNT_W-1:0] kernel_rows_reg;
    logic             fill_bank_reg;
    logic             rd_bank_full_reg;
    logic             fill_bank_full_reg;
    logic             overflow_reg;

    logic [1:0]                 lane_sel  [4];
    logic [SLOT_W-1:0]          slot_data [4];
    logic [MAX_ROWS*SLOT_W-1:0] lane_data [4];

    logic size_ok;
    logic consume_ok;
    logic beat_wr;
    logic last_beat;
    logic do_swap;
    logic enter_hold;
    logic clr_fill;
    logic ovf_set;

    assign lane_sel[0] = kernel_select_0;
    assign lane_sel[1] = kernel_select_1;
    assign lane_sel[2] = kernel_select_2;
    assign lane_sel[3] = kernel_select_3;

    always_comb begin
        size_ok    = (row_size != '0) && (row_size <= CNT_W'(MAX_ROWS));
        consume_ok = kernel_consume && rd_bank_full_reg;
        // load_start wins over a beat arriving in the same cycle
        beat_wr    = (state_reg == FILL) && rdata_valid && !load_start;
        last_beat  = beat_wr && (fill_cnt_reg == size_q_reg - CNT_W'(1));
        do_swap    = (last_beat && (!rd_bank_full_reg || kernel_consume))
                   || ((state_reg == HOLD) && fill_bank_full_reg && consume_ok);
        enter_hold = last_beat && rd_bank_full_reg && !kernel_consume;
        clr_fill   = load_start && (((state_reg == IDLE) && size_ok) || (state_reg == FILL));
        ovf_set    = (state_reg == HOLD) && rdata_valid && !load_start;
    end

    // Per lane/row storage: two cells (one per bank); the read bank is the one not being filled.
    genvar gi, gr;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign slot_data[gi] = kernel_rdata[32'(lane_sel[gi]) * SLOT_W +: SLOT_W];
            for (gr = 0; gr < MAX_ROWS; gr++) begin : g_row
                logic [SLOT_W-1:0] cell_reg [2];
                logic              row_we;

                assign row_we = beat_wr && (fill_cnt_reg == CNT_W'(gr));

                always_ff @(posedge clk) begin
                    for (int b = 0; b < 2; b++) begin
                        if (!reset) begin
                            cell_reg[b] <= '0;
                        end else if ((clr_fill && (fill_bank_reg == 1'(b)))
                                  || (do_swap && (fill_bank_reg != 1'(b)))) begin
                            // the bank about to receive a fresh kernel starts from zero
                            cell_reg[b] <= '0;
                        end else if (row_we && (fill_bank_reg == 1'(b))) begin
                            cell_reg[b] <= slot_data[gi];
                        end
                    end
                end

                assign lane_data[gi][gr*SLOT_W +: SLOT_W] = cell_reg[!fill_bank_reg];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= IDLE;
            fill_cnt_reg       <= '0;
            size_q_reg         <= '0;
            hold_rows_reg      <= '0;
            kernel_rows_reg    <= '0;
            fill_bank_reg      <= 1'b0;
            rd_bank_full_reg   <= 1'b0;
            fill_bank_full_reg <= 1'b0;
            overflow_reg       <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end

            if (do_swap) begin
                fill_bank_reg      <= !fill_bank_reg;
                rd_bank_full_reg   <= 1'b1;
                fill_bank_full_reg <= 1'b0;
                // a waiting kernel keeps the size it was filled with, even if size_q was reloaded
                kernel_rows_reg    <= (state_reg == HOLD) ? hold_rows_reg : size_q_reg;
            end else if (consume_ok) begin
                rd_bank_full_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (load_start && size_ok) begin
                        state_reg    <= FILL;
                        size_q_reg   <= row_size;
                        fill_cnt_reg <= '0;
                    end
                end
                FILL: begin
                    if (load_start) begin
                        fill_cnt_reg <= '0;
                        if (size_ok) begin
                            size_q_reg <= row_size;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (beat_wr) begin
                        if (last_beat) begin
                            fill_cnt_reg <= '0;
                        end else begin
                            fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
                        end
                        if (enter_hold) begin
                            state_reg          <= HOLD;
                            fill_bank_full_reg <= 1'b1;
                            hold_rows_reg      <= size_q_reg;
                        end
                    end
                end
                HOLD: begin
                    if (load_start && size_ok) begin
                        size_q_reg <= row_size;
                    end
                    if (do_swap) begin
                        state_reg <= FILL;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fill_ready    = (state_reg == FILL);
    assign kernel_valid  = rd_bank_full_reg;
    assign kernel_rows   = kernel_rows_reg;
    assign overflow      = overflow_reg;
    assign kernel_data_0 = lane_data[0];
    assign kernel_data_1 = lane_data[1];
    assign kernel_data_2 = lane_data[2];
    assign kernel_data_3 = lane_data[3];

endmodule

// File: tb/tb_kernel_row_buffer.sv
// Bench for kernel_row_buffer: a queue-style kernel model checked every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_kernel_row_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_start;
    logic [4:0]   row_size;
    logic         rdata_valid;
    logic [63:0]  kernel_rdata;
    logic [1:0]   kernel_select_0, kernel_select_1, kernel_select_2, kernel_select_3;
    logic         kernel_consume;
    logic         fill_ready;
    logic         kernel_valid;
    logic [255:0] kernel_data_0, kernel_data_1, kernel_data_2, kernel_data_3;
    logic [4:0]   kernel_rows;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    int cycle_n  = 0;
    bit chk_en   = 0;

    kernel_row_buffer dut (
        .clk(clk), .reset(reset), .load_start(load_start), .row_size(row_size),
        .rdata_valid(rdata_valid), .kernel_rdata(kernel_rdata),
        .kernel_select_0(kernel_select_0), .kernel_select_1(kernel_select_1),
        .kernel_select_2(kernel_select_2), .kernel_select_3(kernel_select_3),
        .kernel_consume(kernel_consume), .fill_ready(fill_ready),
        .kernel_valid(kernel_valid), .kernel_data_0(kernel_data_0),
        .kernel_data_1(kernel_data_1), .kernel_data_2(kernel_data_2),
        .kernel_data_3(kernel_data_3), .kernel_rows(kernel_rows), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // ---------------- model: presented kernel, one waiting kernel, partial kernel
    logic [15:0] m_pres [4][16];
    logic [15:0] m_wait [4][16];
    logic [15:0] m_part [4][16];
    int m_rows, m_wait_rows, m_part_n, m_size;
    bit m_valid, m_waiting, m_active, m_ovf;

    function automatic logic [15:0] slot_of(input logic [63:0] line, input logic [1:0] s);
        return line[s*16 +: 16];
    endfunction

    task automatic model_step();
        bit consumed;
        bit ok;
        logic [1:0] sel [4];
        sel[0] = kernel_select_0; sel[1] = kernel_select_1;
        sel[2] = kernel_select_2; sel[3] = kernel_select_3;
        if (!reset) begin
            for (int l = 0; l < 4; l++)
                for (int r = 0; r < 16; r++) begin
                    m_pres[l][r] = '0; m_wait[l][r] = '0; m_part[l][r] = '0;
                end
            m_rows = 0; m_wait_rows = 0; m_part_n = 0; m_size = 0;
            m_valid = 0; m_waiting = 0; m_active = 0; m_ovf = 0;
            return;
        end
        consumed = kernel_consume && m_valid;
        ok = (row_size >= 1) && (row_size <= 16);
        if (load_start) begin
            if (m_waiting) begin
                if (ok) m_size = int'(row_size);
            end else begin
                m_part_n = 0;
                for (int l = 0; l < 4; l++)
                    for (int r = 0; r < 16; r++) m_part[l][r] = '0;
                if (ok) begin
                    m_active = 1; m_size = int'(row_size);
                end else begin
                    m_active = 0;
                end
            end
        end else if (rdata_valid && m_active) begin
            if (m_waiting) begin
                m_ovf = 1;
            end else begin
                for (int l = 0; l < 4; l++) m_part[l][m_part_n] = slot_of(kernel_rdata, sel[l]);
                m_part_n++;
                if (m_part_n == m_size) begin
                    m_wait = m_part;
                    m_wait_rows = m_size;
                    m_waiting = 1;
                    m_part_n = 0;
                    for (int l = 0; l < 4; l++)
                        for (int r = 0; r < 16; r++) m_part[l][r] = '0;
                end
            end
        end
        if (consumed) m_valid = 0;
        if (m_waiting && !m_valid) begin
            m_pres = m_wait;
            m_rows = m_wait_rows;
            m_valid = 1;
            m_waiting = 0;
            $display("cycle %0d: kernel presented rows=%0d lane0_row0=%h lane3_row0=%h",
                     cycle_n, m_rows, m_pres[0][0], m_pres[3][0]);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cycle_n++;
        model_step();
    end

    function automatic logic [255:0] pack_lane(input int l);
        logic [255:0] v;
        for (int r = 0; r < 16; r++) v[r*16 +: 16] = m_pres[l][r];
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s cycle=%0d got=%h exp=%h", name, cycle_n, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("kernel_valid", 256'(kernel_valid), 256'(m_valid));
            chk("fill_ready", 256'(fill_ready), 256'(m_active && !m_waiting));
            chk("overflow", 256'(overflow), 256'(m_ovf));
            chk("kernel_rows", 256'(kernel_rows), 256'(m_rows));
            chk("data0", kernel_data_0, pack_lane(0));
            chk("data1", kernel_data_1, pack_lane(1));
            chk("data2", kernel_data_2, pack_lane(2));
            chk("data3", kernel_data_3, pack_lane(3));
        end
    end

    // ---------------- stimulus
    function automatic logic [63:0] mk(input logic [15:0] base);
        return {base + 16'd3, base + 16'd2, base + 16'd1, base};
    endfunction

    task automatic cyc(input logic ls, input logic [4:0] rs, input logic rv,
                       input logic [63:0] d, input logic [7:0] sel, input logic cons);
        load_start = ls; row_size = rs; rdata_valid = rv; kernel_rdata = d;
        kernel_select_0 = sel[1:0]; kernel_select_1 = sel[3:2];
        kernel_select_2 = sel[5:4]; kernel_select_3 = sel[7:6];
        kernel_consume = cons;
        @(posedge clk);
        #1;
        load_start = 0; rdata_valid = 0; kernel_consume = 0;
    endtask

    localparam logic [7:0] SEL_ID = 8'b11_10_01_00;
    localparam logic [7:0] SEL_2  = 8'b10_10_10_10;

    initial begin
        reset = 0; load_start = 0; row_size = 0; rdata_valid = 0; kernel_rdata = 0;
        kernel_select_0 = 0; kernel_select_1 = 0; kernel_select_2 = 0; kernel_select_3 = 0;
        kernel_consume = 0;
        cyc(0, 0, 0, 0, 0, 0);
        chk_en = 1;
        cyc(0, 0, 1, mk(16'h1111), 0, 0);
        chk("rst_kv", 256'(kernel_valid), 256'(0));
        chk("rst_fr", 256'(fill_ready), 256'(0));
        chk("rst_rows", 256'(kernel_rows), 256'(0));
        reset = 1;

        // 1: row_size 2, identity selects
        cyc(1, 2, 0, 0, 0, 0);
        cyc(0, 0, 1, mk(16'hA000), SEL_ID, 0);
        chk("t1_not_yet", 256'(kernel_valid), 256'(0));
        cyc(0, 0, 1, mk(16'hB000), SEL_ID, 0);
        chk("t1_kv", 256'(kernel_valid), 256'(1));
        chk("t1_rows", 256'(kernel_rows), 256'(2));
        chk("t1_l1r0", 256'(kernel_data_1[15:0]), 256'(16'hA001));
        chk("t1_l1r1", 256'(kernel_data_1[31:16]), 256'(16'hB001));
        chk("t1_l1hi", 256'(kernel_data_1[255:32]), 256'(0));
        chk("t1_l3r1", 256'(kernel_data_3[31:16]), 256'(16'hB003));
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1_consumed", 256'(kernel_valid), 256'(0));

        // 2: all lanes select slot 2
        cyc(1, 2, 0, 0, 0, 0);
        cyc(0, 0, 1, mk(16'hC000), SEL_2, 0);
        cyc(0, 0, 1, mk(16'hD000), SEL_2, 0);
        chk("t2_l0r0", 256'(kernel_data_0[15:0]), 256'(16'hC002));
        chk("t2_l3r1", 256'(kernel_data_3[31:16]), 256'(16'hD002));
        cyc(0, 0, 0, 0, 0, 1);

        // 3: row_size 1, three beats without consume -> HOLD then overflow
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, mk(16'h1000), SEL_ID, 0);
        cyc(0, 0, 1, mk(16'h2000), SEL_ID, 0);
        chk("t3_hold_fr", 256'(fill_ready), 256'(0));
        chk("t3_no_ovf", 256'(overflow), 256'(0));
        cyc(0, 0, 1, mk(16'h3000), SEL_ID, 0);
        chk("t3_ovf", 256'(overflow), 256'(1));
        chk("t3_k1", 256'(kernel_data_0[15:0]), 256'(16'h1000));
        cyc(0, 0, 0, 0, 0, 1);
        chk("t3_k2_kv", 256'(kernel_valid), 256'(1));
        chk("t3_k2", 256'(kernel_data_2[15:0]), 256'(16'h2002));
        chk("t3_fill", 256'(fill_ready), 256'(1));
        cyc(0, 0, 0, 0, 0, 1);

        // 4: row_size 4, final beat of kernel 2 coincides with consume
        cyc(1, 4, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, mk(16'h4000 + 16'(i * 16)), SEL_ID, 0);
        chk("t4_k1", 256'(kernel_data_0[63:48]), 256'(16'h4030));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, mk(16'h5000 + 16'(i * 16)), SEL_ID, 0);
        cyc(0, 0, 1, mk(16'h5030), SEL_ID, 1);
        chk("t4_kv", 256'(kernel_valid), 256'(1));
        chk("t4_k2", 256'(kernel_data_0[63:48]), 256'(16'h5030));
        chk("t4_fr", 256'(fill_ready), 256'(1));
        cyc(0, 0, 0, 0, 0, 1);

        // 5: abort an 8-row fill with row_size 4 (beat in the load cycle dropped)
        cyc(1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, mk(16'h6000 + 16'(i * 16)), SEL_ID, 0);
        cyc(1, 4, 1, mk(16'h6F00), SEL_ID, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, mk(16'h7000 + 16'(i * 16)), SEL_ID, 0);
        chk("t5_rows", 256'(kernel_rows), 256'(4));
        chk("t5_r0", 256'(kernel_data_1[15:0]), 256'(16'h7001));
        chk("t5_hi", 256'(kernel_data_0[255:64]), 256'(0));
        cyc(1, 0, 0, 0, 0, 0);
        chk("t5_idle_fr", 256'(fill_ready), 256'(0));
        chk("t5_idle_kv", 256'(kernel_valid), 256'(1));
        cyc(0, 0, 1, mk(16'h7700), SEL_ID, 0);
        cyc(0, 0, 0, 0, 0, 1);

        // 6: reset during HOLD
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, mk(16'h8000), SEL_ID, 0);
        cyc(0, 0, 1, mk(16'h9000), SEL_ID, 0);
        reset = 0;
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1;
        chk("t6_kv", 256'(kernel_valid), 256'(0));
        chk("t6_ovf", 256'(overflow), 256'(0));
        chk("t6_data", kernel_data_0, 256'(0));
        chk("t6_rows", 256'(kernel_rows), 256'(0));
        cyc(0, 0, 1, mk(16'hE000), SEL_ID, 0);
        cyc(0, 0, 1, mk(16'hF000), SEL_ID, 0);
        chk("t6_ign_ovf", 256'(overflow), 256'(0));
        chk("t6_ign_kv", 256'(kernel_valid), 256'(0));
        cyc(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_row_buffer.md
Name: kernel_row_buffer

Overview:
- Downstream of the kernel address/select controller; captures kernel ROM rows and delivers whole kernels to the four conv lanes.
- Each cycle the ROM line holds 4 kernel-row slots. Lane n stores the slot chosen by kernel_select_n into row position fill_cnt of its fill bank.
- The buffer is ping-pong (two banks). A completed kernel is presented to the conv lanes with a valid/consume handshake while the next kernel fills.

Parameters:
- SLOT_W, 16, width of one kernel-row slot; ROM line width = 4*SLOT_W.
- MAX_ROWS, 16, maximum rows per kernel; matches the largest stage row size.
- CNT_W, 5, width of row_size and row counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- load_start  in  1  pulse; latches row_size and begins a new fill sequence.
- row_size  in  CNT_W  rows per kernel for the current stage, sampled on load_start.
- rdata_valid  in  1  ROM line valid this cycle; it is read_kernel_enable delayed to align with ROM latency.
- kernel_rdata  in  4*SLOT_W  ROM line; slot s occupies bits [s*SLOT_W +: SLOT_W].
- kernel_select_0..3  in  2 each  slot index for lanes 0..3; already aligned to kernel_rdata.
- kernel_consume  in  1  pulse from the conv lanes; the presented kernel is used up.
- fill_ready  out  1  a beat can be accepted this cycle.
- kernel_valid  out  1  a complete kernel is presented.
- kernel_data_0..3  out  MAX_ROWS*SLOT_W each  presented kernel per lane; row r occupies [r*SLOT_W +: SLOT_W].
- kernel_rows  out  CNT_W  row count of the presented kernel.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (reset==0 at a clk edge) clears:
  - both banks to zero;
  - fill_cnt=0, fill_bank=0, rd_bank_full=0, fill_bank_full=0, size_q=0;
  - outputs: kernel_valid=0, fill_ready=0, kernel_rows=0, overflow=0, all kernel_data=0;
  - FSM to IDLE.
- Reset mid-fill discards all partial and complete kernels.
- FSM states:
  - IDLE: fill_ready=0; rdata_valid is ignored and does not set overflow.
    - load_start with row_size in 1..MAX_ROWS -> FILL; size_q=row_size; fill_cnt=0; fill bank cleared to zero.
    - load_start with row_size==0 or row_size>MAX_ROWS -> stay in IDLE.
  - FILL: fill_ready=1.
    - Each rdata_valid beat writes lane n row fill_cnt = slot kernel_select_n, then fill_cnt++.
    - On the beat where fill_cnt==size_q-1: fill bank becomes complete and fill_cnt=0.
      - If the read bank is free, the banks swap that edge, so kernel_valid=1 on the next cycle (1-cycle latency from last beat). The new fill bank is cleared and the FSM stays in FILL.
      - Otherwise -> HOLD.
  - HOLD: fill_ready=0.
    - On kernel_consume, the banks swap at that edge: kernel_valid stays 1, the new contents are visible the next cycle, the new fill bank is cleared, -> FILL.
- Filling continues kernel after kernel with no new load_start; size_q is held.
- Consume rules:
  - kernel_consume with kernel_valid=1 and no bank waiting -> kernel_valid=0 next cycle.
  - kernel_consume with kernel_valid=0 is ignored.
- Simultaneous final beat and kernel_consume while in FILL with the read bank full: the swap happens that edge, kernel_valid stays 1 with the new kernel, and the FSM does not enter HOLD.
- load_start in FILL aborts the partial kernel only:
  - fill_cnt=0, fill bank cleared, size_q reloaded;
  - a presented kernel is unaffected.
  - If row_size is invalid -> IDLE, and the presented kernel stays until consumed.
- load_start in HOLD: size_q is reloaded and takes effect from the next fill; the complete waiting bank is kept.
- load_start has priority over rdata_valid in the same cycle; that beat is dropped and does not set overflow.
- rdata_valid while fill_ready=0 in FILL or HOLD: the beat is dropped and overflow=1. overflow clears only on reset.
- kernel_rows is registered with the presented kernel (the size_q it was filled with).
- Rows at index >= size_q read zero.

Test Plan:
- Reset, then load_start with row_size=2; beats with slots {A0..A3}, {B0..B3}; selects (0,1,2,3) -> next cycle kernel_valid=1, kernel_rows=2, kernel_data_1 row0=A1, row1=B1, rows 2..15=0.
- Stage-1 style selects all=2, row_size=2, beats X then Y -> every lane holds slot 2 of X and Y.
- row_size=1, 3 consecutive beats with no consume -> kernel 1 presented; kernel 2 fills then HOLD with fill_ready=0; beat 3 sets overflow=1; one kernel_consume -> kernel 2 presented.
- row_size=4, kernel 1 presented; final beat of kernel 2 in the same cycle as kernel_consume -> kernel_valid stays 1, kernel 2 data next cycle, FSM in FILL.
- row_size=8, 3 beats, then load_start row_size=4, then 4 beats -> presented kernel has 4 rows from the new beats only, kernel_rows=4; then load_start row_size=0 -> IDLE.
- reset deasserted to 0 for one cycle during HOLD -> all outputs zero, FSM IDLE, subsequent beats ignored with overflow=0.
